// File: rtl/cgram_ctrl.sv
// cgram_ctrl: 256 x 15-bit BGR555 palette RAM with its B-bus register front end.
//   CPU side : $2121 CGADD, $2122 CGDATA (two-byte write), $213B CGDATAREAD
//              (two-byte read), $2132 COLDATA (fixed sub-screen colour).
//   Mixer    : cgram_addr -> cgram_rdata, one-cycle latency, serviced every cycle.
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   cpu_addr/wr/rd/wdata B-bus register access (low address byte, 1-cycle strobes)
//   cpu_rdata            registered $213B read data, held until the next $213B read
//   open_bus_msb         PPU2 open-bus bit 7 returned on high-byte reads
//   render_active        1 = PPU fetching pixels; CPU accesses then hit cgram_addr
//   cgram_addr/rdata     mixer palette lookup
//   sub_backdrop         fixed colour {B,G,R} set through COLDATA
module cgram_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  cpu_addr,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    input  logic        open_bus_msb,
    input  logic        render_active,
    input  logic [7:0]  cgram_addr,
    output logic [14:0] cgram_rdata,
    output logic [14:0] sub_backdrop
);

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 15;
    localparam int unsigned DEPTH  = 256;

    localparam logic [7:0] REG_CGADD   = 8'h21;
    localparam logic [7:0] REG_CGDATA  = 8'h22;
    localparam logic [7:0] REG_COLDATA = 8'h32;
    localparam logic [7:0] REG_CGREAD  = 8'h3B;

    // Byte phase shared by $2122 writes and $213B reads.
    typedef enum logic {
        FF_LOW  = 1'b0,
        FF_HIGH = 1'b1
    } ff_t;

    logic [DATA_W-1:0] mem [DEPTH];

    ff_t               ff_q, ff_d;
    logic [ADDR_W-1:0] cgadd_q, cgadd_d;
    logic [7:0]        latch_q, latch_d;
    logic [DATA_W-1:0] fixcol_q, fixcol_d;
    logic [7:0]        rdata_d;

    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] target_addr;
    logic [DATA_W-1:0] target_word;

    logic wr_cgadd, wr_cgdata, wr_coldata, rd_cgdata;

    // Register decode; a simultaneous write suppresses the read.
    assign wr_cgadd   = cpu_wr && (cpu_addr == REG_CGADD);
    assign wr_cgdata  = cpu_wr && (cpu_addr == REG_CGDATA);
    assign wr_coldata = cpu_wr && (cpu_addr == REG_COLDATA);
    assign rd_cgdata  = cpu_rd && !cpu_wr && (cpu_addr == REG_CGREAD);

    // During rendering the CPU port lands on whatever the mixer is addressing.
    assign target_addr = render_active ? cgram_addr : cgadd_q;
    assign target_word = mem[target_addr];

    // Register state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ff_q      <= FF_LOW;
            cgadd_q   <= '0;
            latch_q   <= '0;
            fixcol_q  <= '0;
            cpu_rdata <= '0;
        end else begin
            ff_q      <= ff_d;
            cgadd_q   <= cgadd_d;
            latch_q   <= latch_d;
            fixcol_q  <= fixcol_d;
            cpu_rdata <= rdata_d;
        end
    end

    // Next-state logic for the byte-phase FSM and the CPU-visible registers.
    always_comb begin
        ff_d      = ff_q;
        cgadd_d   = cgadd_q;
        latch_d   = latch_q;
        fixcol_d  = fixcol_q;
        rdata_d   = cpu_rdata;
        mem_we    = 1'b0;
        mem_wdata = '0;

        if (wr_cgadd) begin
            cgadd_d = cpu_wdata;
            ff_d    = FF_LOW;
        end else if (wr_cgdata) begin
            case (ff_q)
                FF_LOW: begin
                    latch_d = cpu_wdata;
                    ff_d    = FF_HIGH;
                end
                FF_HIGH: begin
                    mem_we    = 1'b1;
                    mem_wdata = {cpu_wdata[6:0], latch_q};
                    ff_d      = FF_LOW;
                    cgadd_d   = cgadd_q + ADDR_W'(1);
                end
                default: ff_d = FF_LOW;
            endcase
        end else if (wr_coldata) begin
            if (cpu_wdata[5]) fixcol_d[4:0]   = cpu_wdata[4:0];
            if (cpu_wdata[6]) fixcol_d[9:5]   = cpu_wdata[4:0];
            if (cpu_wdata[7]) fixcol_d[14:10] = cpu_wdata[4:0];
        end else if (rd_cgdata) begin
            case (ff_q)
                FF_LOW: begin
                    rdata_d = target_word[7:0];
                    ff_d    = FF_HIGH;
                end
                FF_HIGH: begin
                    rdata_d = {open_bus_msb, target_word[14:8]};
                    ff_d    = FF_LOW;
                    cgadd_d = cgadd_q + ADDR_W'(1);
                end
                default: ff_d = FF_LOW;
            endcase
        end
    end

    // Palette storage; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[target_addr] <= mem_wdata;
        end
    end

    // Mixer lookup; samples the array before a same-edge write lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cgram_rdata <= '0;
        end else begin
            cgram_rdata <= mem[cgram_addr];
        end
    end

    assign sub_backdrop = fixcol_q;

endmodule

// File: tb/tb_cgram_ctrl.sv
// Directed, table-driven bench for cgram_ctrl.
module tb_cgram_ctrl;

    logic        clk;
    logic        reset_n;
    logic [7:0]  cpu_addr;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        open_bus_msb;
    logic        render_active;
    logic [7:0]  cgram_addr;
    logic [14:0] cgram_rdata;
    logic [14:0] sub_backdrop;

    int checks = 0;
    int errors = 0;

    cgram_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cpu_addr      (cpu_addr),
        .cpu_wr        (cpu_wr),
        .cpu_rd        (cpu_rd),
        .cpu_wdata     (cpu_wdata),
        .cpu_rdata     (cpu_rdata),
        .open_bus_msb  (open_bus_msb),
        .render_active (render_active),
        .cgram_addr    (cgram_addr),
        .cgram_rdata   (cgram_rdata),
        .sub_backdrop  (sub_backdrop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic        render;
        logic [7:0]  caddr;
        logic        obm;
        logic        chk_rd;
        logic [7:0]  exp_rd;
        logic        chk_pal;
        logic [14:0] exp_pal;
        logic        chk_sub;
        logic [14:0] exp_sub;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t idle();
        vec_t v;
        v.wr = 1'b0; v.rd = 1'b0; v.addr = 8'h00; v.wdata = 8'h00;
        v.render = 1'b0; v.caddr = 8'h00; v.obm = 1'b0;
        v.chk_rd = 1'b0; v.exp_rd = 8'h00;
        v.chk_pal = 1'b0; v.exp_pal = 15'h0;
        v.chk_sub = 1'b0; v.exp_sub = 15'h0;
        return v;
    endfunction

    function automatic vec_t w(input logic [7:0] a, input logic [7:0] d);
        vec_t v = idle();
        v.wr = 1'b1; v.addr = a; v.wdata = d;
        return v;
    endfunction

    function automatic vec_t r(input logic obm);
        vec_t v = idle();
        v.rd = 1'b1; v.addr = 8'h3B; v.obm = obm;
        return v;
    endfunction

    function automatic vec_t at(input vec_t vi, input logic [7:0] a);
        vec_t v = vi;
        v.caddr = a;
        return v;
    endfunction

    function automatic vec_t ra(input vec_t vi);
        vec_t v = vi;
        v.render = 1'b1;
        return v;
    endfunction

    function automatic vec_t xp(input vec_t vi, input logic [14:0] e);
        vec_t v = vi;
        v.chk_pal = 1'b1; v.exp_pal = e;
        return v;
    endfunction

    function automatic vec_t xr(input vec_t vi, input logic [7:0] e);
        vec_t v = vi;
        v.chk_rd = 1'b1; v.exp_rd = e;
        return v;
    endfunction

    function automatic vec_t xs(input vec_t vi, input logic [14:0] e);
        vec_t v = vi;
        v.chk_sub = 1'b1; v.exp_sub = e;
        return v;
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check15(input string name, input logic [14:0] act, input logic [14:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One vector = one clock: drive on the falling edge, check just after the rising edge.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        cpu_wr        = v.wr;
        cpu_rd        = v.rd;
        cpu_addr      = v.addr;
        cpu_wdata     = v.wdata;
        render_active = v.render;
        cgram_addr    = v.caddr;
        open_bus_msb  = v.obm;
        @(posedge clk);
        #1;
        if (v.chk_rd)  check8 ({tag, " cpu_rdata"},    cpu_rdata,    v.exp_rd);
        if (v.chk_pal) check15({tag, " cgram_rdata"},  cgram_rdata,  v.exp_pal);
        if (v.chk_sub) check15({tag, " sub_backdrop"}, sub_backdrop, v.exp_sub);
    endtask

    initial begin
        reset_n = 1'b0;
        cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
        open_bus_msb = 1'b0; render_active = 1'b0; cgram_addr = 8'h00;

        // Basic write and lookup, cgadd post-increment, bit 7 of high byte discarded.
        vecs.push_back(w(8'h21, 8'h10));
        vecs.push_back(w(8'h22, 8'h1F));
        vecs.push_back(w(8'h22, 8'h7C));
        vecs.push_back(xp(at(idle(), 8'h10), 15'h7C1F));
        vecs.push_back(w(8'h22, 8'hEF));
        vecs.push_back(w(8'h22, 8'hBE));
        vecs.push_back(xp(at(idle(), 8'h11), 15'h3EEF));
        // cgadd wrap $FF -> $00.
        vecs.push_back(w(8'h21, 8'hFF));
        vecs.push_back(w(8'h22, 8'h34));
        vecs.push_back(w(8'h22, 8'h12));
        vecs.push_back(w(8'h22, 8'h78));
        vecs.push_back(w(8'h22, 8'h56));
        vecs.push_back(xp(at(idle(), 8'hFF), 15'h1234));
        vecs.push_back(xp(at(idle(), 8'h00), 15'h5678));
        // $213B reads with open-bus bit 7, data held afterwards.
        vecs.push_back(w(8'h21, 8'h20));
        vecs.push_back(w(8'h22, 8'hBC));
        vecs.push_back(w(8'h22, 8'h5A));
        vecs.push_back(w(8'h21, 8'h20));
        vecs.push_back(xr(r(1'b1), 8'hBC));
        vecs.push_back(xr(r(1'b1), 8'hDA));
        vecs.push_back(xr(idle(), 8'hDA));
        vecs.push_back(w(8'h21, 8'h20));
        vecs.push_back(xr(r(1'b0), 8'hBC));
        vecs.push_back(xr(r(1'b0), 8'h5A));
        // Read-before-write on a same-cycle mixer lookup.
        vecs.push_back(w(8'h21, 8'h30));
        vecs.push_back(w(8'h22, 8'hAA));
        vecs.push_back(w(8'h22, 8'h55));
        vecs.push_back(w(8'h21, 8'h30));
        vecs.push_back(w(8'h22, 8'h11));
        vecs.push_back(xp(at(w(8'h22, 8'h22), 8'h30), 15'h55AA));
        vecs.push_back(xp(at(idle(), 8'h30), 15'h2211));
        // Back-to-back lookups of different addresses.
        vecs.push_back(xp(at(idle(), 8'h10), 15'h7C1F));
        vecs.push_back(xp(at(idle(), 8'hFF), 15'h1234));
        vecs.push_back(xp(at(idle(), 8'h10), 15'h7C1F));
        vecs.push_back(xp(at(idle(), 8'h20), 15'h5ABC));
        // Mid-render write goes to cgram_addr, cgadd still increments.
        vecs.push_back(w(8'h21, 8'h03));
        vecs.push_back(w(8'h22, 8'h02));
        vecs.push_back(w(8'h22, 8'h01));
        vecs.push_back(w(8'h21, 8'h03));
        vecs.push_back(ra(at(w(8'h22, 8'hFF), 8'h80)));
        vecs.push_back(ra(at(w(8'h22, 8'h7F), 8'h80)));
        vecs.push_back(xp(at(idle(), 8'h80), 15'h7FFF));
        vecs.push_back(xp(at(idle(), 8'h03), 15'h0102));
        vecs.push_back(w(8'h22, 8'h44));
        vecs.push_back(w(8'h22, 8'h33));
        vecs.push_back(xp(at(idle(), 8'h04), 15'h3344));
        // Mid-render read also follows cgram_addr.
        vecs.push_back(w(8'h21, 8'h00));
        vecs.push_back(xr(ra(at(r(1'b0), 8'h10)), 8'h1F));
        vecs.push_back(xp(xr(ra(at(r(1'b0), 8'h10)), 8'h7C), 15'h7C1F));
        // Reads and writes share the byte phase; the latch keeps its last low byte.
        vecs.push_back(w(8'h21, 8'h40));
        vecs.push_back(w(8'h22, 8'hCD));
        vecs.push_back(w(8'h22, 8'h0B));
        vecs.push_back(w(8'h21, 8'h40));
        vecs.push_back(xr(r(1'b0), 8'hCD));
        vecs.push_back(w(8'h22, 8'h77));
        vecs.push_back(xp(at(idle(), 8'h40), 15'h77CD));
        // Write+read strobes together: read ignored; foreign address ignored.
        begin
            vec_t both = w(8'h3B, 8'h55);
            both.rd = 1'b1;
            vecs.push_back(xr(both, 8'hCD));
        end
        vecs.push_back(w(8'h22, 8'h12));
        vecs.push_back(w(8'h23, 8'h99));
        vecs.push_back(w(8'h22, 8'h34));
        vecs.push_back(xp(at(idle(), 8'h41), 15'h3412));
        // COLDATA field selects.
        vecs.push_back(xs(w(8'h32, 8'h3F), 15'h001F));
        vecs.push_back(xs(w(8'h32, 8'hCA), 15'h295F));
        vecs.push_back(xs(w(8'h32, 8'h00), 15'h295F));
        vecs.push_back(xs(idle(), 15'h295F));
        vecs.push_back(xs(w(8'h32, 8'hE3), 15'h0C63));
        vecs.push_back(xs(w(8'h32, 8'h50), 15'h0E03));

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check8 ("reset cpu_rdata",    cpu_rdata,    8'h00);
        check15("reset cgram_rdata",  cgram_rdata,  15'h0000);
        check15("reset sub_backdrop", sub_backdrop, 15'h0000);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset between the two bytes of a $2122 pair.
        apply(w(8'h21, 8'h05), "rst_a");
        apply(w(8'h22, 8'hAA), "rst_b");
        @(negedge clk);
        cpu_wr = 1'b0; cpu_rd = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        check8 ("midreset cpu_rdata",    cpu_rdata,    8'h00);
        check15("midreset cgram_rdata",  cgram_rdata,  15'h0000);
        check15("midreset sub_backdrop", sub_backdrop, 15'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        // cgadd back at 0 and phase LOW: the next pair lands at $00.
        apply(w(8'h22, 8'h11), "post_a");
        apply(w(8'h22, 8'h22), "post_b");
        apply(xp(at(idle(), 8'h00), 15'h2211), "post_addr0");
        apply(w(8'h21, 8'h05), "post_c");
        apply(w(8'h22, 8'h11), "post_d");
        apply(w(8'h22, 8'h22), "post_e");
        apply(xp(at(idle(), 8'h05), 15'h2211), "post_addr5");
        apply(xs(idle(), 15'h0000), "post_sub");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
